// File: rtl/or16_frame_accum_pkg.sv
// ---------------------------------------------------------------------------
// or16_frame_accum_pkg
//
// Shared definitions for the frame OR-accumulator:
//   - DATA_W  : datapath width, fixed by the or16gate reduction element.
//   - state_e : frame FSM state encoding. The unused code 2'd3 is treated as
//               IDLE by the FSM so a corrupted state register recovers on the
//               next clock edge.
// ---------------------------------------------------------------------------
package or16_frame_accum_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // waiting for the first beat of a frame
    ACC  = 2'd1,  // frame in progress, OR-ing further beats into acc
    HOLD = 2'd2   // result presented downstream, waiting for handoff
  } state_e;

endpackage : or16_frame_accum_pkg

// File: rtl/or16_frame_accum_or16gate.sv
// ---------------------------------------------------------------------------
// or16gate
//
// Combinational 16-bit bitwise OR. Used by or16_frame_accum as the reduction
// datapath (x = running accumulator, y = incoming word).
//
// Ports:
//   x   input  [15:0]  first operand
//   y   input  [15:0]  second operand
//   out output [15:0]  x | y
// ---------------------------------------------------------------------------
module or16gate (
  input  logic [15:0] x,
  input  logic [15:0] y,
  output logic [15:0] out
);

  assign out = x | y;

endmodule : or16gate

// File: rtl/or16_frame_accum.sv
// ---------------------------------------------------------------------------
// or16_frame_accum
//
// Reduces a framed stream of 16-bit words to one word per frame by bitwise
// OR, and reports how many words the frame contained (saturating) plus a
// saturation flag. Input and output both use a valid/ready handshake.
//
// Parameters:
//   CNT_W      width of the per-frame beat counter; saturates at 2^CNT_W-1.
//
// Ports:
//   clk        input           rising-edge clock
//   rst_n      input           asynchronous active-low reset
//   in_valid   input           upstream word valid
//   in_ready   output          block can accept a word (low only in HOLD)
//   in_data    input  [15:0]   upstream word
//   in_last    input           final word of the frame
//   out_valid  output          frame result valid (high only in HOLD)
//   out_ready  input           downstream accepts the result
//   out_data   output [15:0]   OR of all words in the frame
//   out_count  output [CNT_W]  words accepted in the frame (saturating)
//   out_sat    output          beat count reached 2^CNT_W-1
//
// Timing: out_valid rises the cycle after the last beat is accepted; the
// next frame's first beat can be accepted the cycle after the handoff.
// in_ready is a pure decode of the state register, so there is no
// combinational path from out_ready to in_ready.
// ---------------------------------------------------------------------------
module or16_frame_accum
  import or16_frame_accum_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   acc_q,   acc_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                sat_q,   sat_d;

  logic [DATA_W-1:0]   or_next;
  logic                beat;

  // Reduction datapath: running accumulator OR incoming word.
  or16gate u_or16gate (
    .x   (acc_q),
    .y   (in_data),
    .out (or_next)
  );

  // Only HOLD stalls the input; decoded from the registered state alone.
  assign in_ready = (state_q != HOLD);
  assign beat     = in_valid && in_ready;

  // Next-state logic. Registers only move on an accepted beat or handoff,
  // so in_data is never sampled while in_valid is low.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it
    // unassigned; that is what keeps this block from inferring latches.
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    sat_d   = sat_q;

    unique case (state_q)
      IDLE: begin
        if (beat) begin
          // First word loads directly; stale acc from the last frame is dropped.
          acc_d   = in_data;
          count_d = CNT_ONE;
          sat_d   = (CNT_W == 1);
          state_d = in_last ? HOLD : ACC;
        end
      end

      ACC: begin
        if (beat) begin
          acc_d = or_next;
          if (count_q != CNT_MAX) begin
            count_d = count_q + CNT_ONE;
          end
          // Set once this beat brings the count to all-ones; sticky after.
          sat_d   = sat_q || (count_q >= (CNT_MAX - CNT_ONE));
          state_d = in_last ? HOLD : ACC;
        end
      end

      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        // Unused encoding 2'd3: recover to IDLE, data registers untouched.
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      sat_q   <= sat_d;
    end
  end

  // Outputs come straight from registers; they are only meaningful in HOLD.
  assign out_valid = (state_q == HOLD);
  assign out_data  = acc_q;
  assign out_count = count_q;
  assign out_sat   = sat_q;

endmodule : or16_frame_accum

// File: tb/tb_or16_frame_accum.sv
// ---------------------------------------------------------------------------
// tb_or16_frame_accum
//
// Two instances share one input stream: dut_a (CNT_W=8) and dut_b (CNT_W=2).
// Timing does not depend on CNT_W, so both see identical handshakes; the
// narrow instance exercises counter saturation with short frames.
// Expected frames are built from the words actually accepted (OR of words,
// count = min(n, 2^W-1), sat = n >= 2^W-1) and compared by a monitor on
// every cycle a result is presented.
// ---------------------------------------------------------------------------
module tb_or16_frame_accum;

  localparam int W_A = 8;
  localparam int W_B = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid;
  logic              in_last;
  logic [15:0]       in_data;
  logic              out_ready;

  logic              in_ready_a, out_valid_a, out_sat_a;
  logic [15:0]       out_data_a;
  logic [W_A-1:0]    out_count_a;
  logic              in_ready_b, out_valid_b, out_sat_b;
  logic [15:0]       out_data_b;
  logic [W_B-1:0]    out_count_b;

  or16_frame_accum #(.CNT_W(W_A)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready_a),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid_a),
    .out_ready (out_ready),
    .out_data  (out_data_a),
    .out_count (out_count_a),
    .out_sat   (out_sat_a)
  );

  or16_frame_accum #(.CNT_W(W_B)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready_b),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid_b),
    .out_ready (out_ready),
    .out_data  (out_data_b),
    .out_count (out_count_b),
    .out_sat   (out_sat_b)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic finish_run();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [15:0] data;
    int          n;
  } frame_t;

  frame_t      exp_q[$];
  logic [15:0] cur_or;
  int          cur_n;

  function automatic int exp_count(input int n, input int w);
    int m;
    m = (1 << w) - 1;
    return (n > m) ? m : n;
  endfunction

  function automatic logic exp_sat(input int n, input int w);
    return n >= ((1 << w) - 1);
  endfunction

  // ---------------- out_ready driver ----------------
  // 0: always ready, 1: random, 2: driven directly by the main sequence.
  int rdy_mode = 2;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0) out_ready = 1'b1;
      else if (rdy_mode == 1) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- output monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (out_valid_a) begin
          if (exp_q.size() == 0) begin
            check("no_frame_expected", 32'(out_valid_a), 32'd0);
          end else begin
            check("data_a",  32'(out_data_a),  32'(exp_q[0].data));
            check("count_a", 32'(out_count_a), 32'(exp_count(exp_q[0].n, W_A)));
            check("sat_a",   32'(out_sat_a),   32'(exp_sat(exp_q[0].n, W_A)));
            check("valid_b", 32'(out_valid_b), 32'd1);
            check("data_b",  32'(out_data_b),  32'(exp_q[0].data));
            check("count_b", 32'(out_count_b), 32'(exp_count(exp_q[0].n, W_B)));
            check("sat_b",   32'(out_sat_b),   32'(exp_sat(exp_q[0].n, W_B)));
            check("in_ready_in_hold", 32'(in_ready_a), 32'd0);
            if (out_ready) void'(exp_q.pop_front());
          end
        end else if (out_valid_b) begin
          check("valid_b_alone", 32'(out_valid_b), 32'd0);
        end
      end
    end
  end

  // ---------------- input driver ----------------
  // Presents a word and keeps in_valid high until accepted; returns at
  // posedge+1 (or at the following negedge for a last word, after checking
  // that the result appears one cycle after the last beat).
  task automatic send_word(input logic [15:0] d, input logic last);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (in_ready_a) begin
        ok = 1'b1;
        break;
      end
    end
    check("accept_timeout", 32'(ok), 32'd1);
    if (!ok) finish_run();
    check("in_ready_b", 32'(in_ready_b), 32'd1);
    @(posedge clk);
    cur_or = (cur_n == 0) ? d : (cur_or | d);
    cur_n++;
    if (last) begin
      exp_q.push_back('{data: cur_or, n: cur_n});
      cur_n = 0;
    end
    #1;
    if (last) begin
      @(negedge clk);
      check("latency_valid_a", 32'(out_valid_a), 32'd1);
      check("latency_valid_b", 32'(out_valid_b), 32'd1);
    end
  endtask

  // Drops in_valid with junk on data/last, then idles n cycles.
  task automatic gap(input int n);
    in_valid = 1'b0;
    in_data  = 16'($urandom);
    in_last  = 1'($urandom_range(0, 1));
    repeat (n) @(posedge clk);
    if (n > 0) #1;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    cur_n = 0;
    #1;
    check("rst_async_valid_a", 32'(out_valid_a), 32'd0);
    check("rst_async_valid_b", 32'(out_valid_b), 32'd0);
    check("rst_async_ready_a", 32'(in_ready_a), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [15:0] w;
    int          len;

    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    cur_or    = '0;
    cur_n     = 0;

    // Reset, then idle 5 cycles.
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_valid_a", 32'(out_valid_a), 32'd0);
    check("rst_ready_a", 32'(in_ready_a),  32'd1);
    check("rst_data_a",  32'(out_data_a),  32'h0000);
    check("rst_count_a", 32'(out_count_a), 32'd0);
    check("rst_sat_a",   32'(out_sat_a),   32'd0);
    check("rst_valid_b", 32'(out_valid_b), 32'd0);
    check("rst_count_b", 32'(out_count_b), 32'd0);

    // 3-word frame, always ready.
    @(posedge clk);
    #1;
    rdy_mode = 0;
    send_word(16'h1263, 1'b0);
    send_word(16'h2462, 1'b0);
    send_word(16'h0001, 1'b1);
    gap(0);
    check("t3w_data",  32'(out_data_a),  32'h3663);
    check("t3w_count", 32'(out_count_a), 32'd3);
    check("t3w_sat",   32'(out_sat_a),   32'd0);
    @(negedge clk);
    check("t3w_valid_drop", 32'(out_valid_a), 32'd0);

    // Single-word frame under 4 cycles of backpressure.
    @(posedge clk);
    #1;
    rdy_mode  = 2;
    out_ready = 1'b0;
    send_word(16'h8000, 1'b1);
    gap(0);
    for (int i = 0; i < 4; i++) begin
      check("bp_valid", 32'(out_valid_a), 32'd1);
      check("bp_data",  32'(out_data_a),  32'h8000);
      check("bp_ready", 32'(in_ready_a),  32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_ready_after", 32'(in_ready_a),  32'd1);
    check("bp_valid_after", 32'(out_valid_a), 32'd0);

    // Back-to-back frames with in_valid held high.
    @(posedge clk);
    #1;
    rdy_mode = 0;
    send_word(16'h0001, 1'b1);
    send_word(16'h0000, 1'b0);
    send_word(16'h0002, 1'b1);
    gap(0);
    check("b2b_data2",  32'(out_data_a),  32'h0002);
    check("b2b_count2", 32'(out_count_a), 32'd2);
    wait_drain("b2b_drain");

    // 5-word frame: saturates the 2-bit counter only.
    for (int i = 0; i < 5; i++) send_word(16'h0001, 1'(i == 4));
    gap(0);
    check("sat5_count_b", 32'(out_count_b), 32'd3);
    check("sat5_sat_b",   32'(out_sat_b),   32'd1);
    check("sat5_data_b",  32'(out_data_b),  32'h0001);
    check("sat5_count_a", 32'(out_count_a), 32'd5);
    wait_drain("sat5_drain");

    // Reset mid-frame, then a fresh single-word frame.
    send_word(16'hFFFF, 1'b0);
    send_word(16'hFFFF, 1'b0);
    gap(0);
    apply_reset();
    send_word(16'h0010, 1'b1);
    gap(0);
    check("rmf_data",  32'(out_data_a),  32'h0010);
    check("rmf_count", 32'(out_count_a), 32'd1);
    check("rmf_sat",   32'(out_sat_a),   32'd0);
    wait_drain("rmf_drain");

    // Reset while holding a result.
    @(posedge clk);
    #1;
    rdy_mode  = 2;
    out_ready = 1'b0;
    send_word(16'h00AA, 1'b1);
    gap(0);
    apply_reset();
    @(negedge clk);
    check("rhold_valid", 32'(out_valid_a), 32'd0);
    check("rhold_ready", 32'(in_ready_a),  32'd1);

    // Randomized frames with random gaps and random backpressure.
    @(posedge clk);
    #1;
    rdy_mode = 1;
    for (int f = 0; f < 80; f++) begin
      if (f == 10)      len = 254;
      else if (f == 30) len = 255;
      else if (f == 50) len = 270;
      else              len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++) begin
        w = 16'($urandom) & 16'($urandom) & 16'($urandom);
        send_word(w, 1'(k == len - 1));
        if ($urandom_range(0, 3) == 0) gap($urandom_range(0, 2));
      end
      if ($urandom_range(0, 1) == 0) gap($urandom_range(0, 3));
    end
    gap(0);
    wait_drain("rand_drain");

    finish_run();
  end

endmodule : tb_or16_frame_accum
